memory_bus_arbiter: RTL and testbench
=====================================

MEMORY_BUS_ARBITER -- requirements
Module: memory_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: ISSUE+WAIT cycles allowed before an outstanding transaction is abandoned.
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 f_req_valid  input  1  fetch stage read request.
REQ-005 f_req_addr  input  21  fetch physical address (phys_memory_address_t).
REQ-006 f_req_ready  output  1  request accepted this cycle.
REQ-007 f_resp_valid  output  1  fetch read data valid, one-cycle pulse.
REQ-008 f_resp_data  output  64  fetch read data.
REQ-009 s_req_valid  input  1  load/store request.
REQ-010 s_req_write  input  1  1 = write, 0 = read.
REQ-011 s_req_addr  input  21  load/store physical address.
REQ-012 s_req_wdata  input  64  write data.
REQ-013 s_req_ready  output  1  request accepted this cycle.
REQ-014 s_resp_valid  output  1  read data or write ack, one-cycle pulse.
REQ-015 s_resp_data  output  64  read data; 0 for write ack.
REQ-016 m_req_valid / m_req_write  output  1 / 1  request toward DRAM.
REQ-017 m_req_addr / m_req_wdata  output  21 / 64  DRAM address, write data.
REQ-018 m_req_ready  input  1  DRAM accepts request.
REQ-019 m_resp_valid / m_resp_data  input  1 / 64  DRAM completion, read data.
REQ-020 timeout_err  output  1  sticky: a transaction timed out.

Function
REQ-021 FSM states IDLE, ISSUE, WAIT, RESP; exactly one transaction outstanding at any time.
REQ-022 IDLE, any *_req_valid: pick owner, latch its addr/write/wdata (fetch forces write=0), pulse owner's *_req_ready for that cycle only, go ISSUE.
REQ-023 Both valid in IDLE: grant the requester not granted last (round-robin); after reset last-grant = store, so fetch wins the first tie.
REQ-024 A single valid requester is granted regardless of last-grant; last-grant updates on every grant.
REQ-025 ISSUE: m_req_valid=1 with latched fields held stable; on m_req_ready=1 go WAIT next cycle.
REQ-026 WAIT: on m_resp_valid=1 register m_resp_data (0 for writes) and go RESP.
REQ-027 RESP: owner's *_resp_valid=1 for exactly one cycle with registered data, other resp_valid=0; go IDLE.
REQ-028 No grant in RESP; new grant earliest in the IDLE cycle after RESP. Minimum accept-to-response latency with ready/resp immediate: 3 cycles.
REQ-029 m_resp_valid in IDLE, ISSUE or RESP is ignored.
REQ-030 8-bit-wide-or-larger counter clears on grant, increments in ISSUE and WAIT; at TIMEOUT_CYCLES set timeout_err, drop m_req_valid, go IDLE, no response pulse.
REQ-031 timeout_err clears only on reset.
REQ-032 Requester deasserting valid after grant does not cancel the transaction.

Reset
REQ-033 rst_n low: state=IDLE, last-grant=store, counter=0, timeout_err=0, all ready/valid outputs 0, data/address outputs 0, immediately and asynchronously.
REQ-034 Reset mid-transaction abandons it; no response is issued after release.

Structure
REQ-035 Shared package: phys_memory_address_t (21 bits), 64-bit memory word type, arbiter state enum, requester-id enum (FETCH, STORE).
REQ-036 Single module; no sub-module.

Verification
REQ-037 Fetch read 0x00100 only, DRAM ready and resp immediate with 0xDEAD_BEEF -> f_req_ready pulse, f_resp_valid 3 cycles later with 0xDEAD_BEEF, s_resp_valid stays 0.
REQ-038 Both valid from reset, held -> grants F,S,F,S; each response goes only to its owner.
REQ-039 Store write 0x00200 data 0x1234, m_req_ready held 0 for 5 cycles -> m_req_* stable all 5 cycles; s_resp_valid with data 0 after resp.
REQ-040 TIMEOUT_CYCLES=8, DRAM never responds -> timeout_err=1 after 8 cycles, FSM back in IDLE, next fetch serviced normally, timeout_err stays 1.
REQ-041 rst_n pulsed low during WAIT -> outputs 0 immediately; late m_resp_valid after release yields no *_resp_valid.

Source files
------------

// File: rtl/memory_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : memory_bus_arbiter_pkg
// Description : Shared types for the fetch/store memory bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package memory_bus_arbiter_pkg;

    localparam int ADDR_W = 21;
    localparam int DATA_W = 64;

    typedef logic [ADDR_W-1:0] phys_memory_address_t;
    typedef logic [DATA_W-1:0] mem_word_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        REQ_FETCH = 1'b0,
        REQ_STORE = 1'b1
    } requester_t;

    // Timeout counter is at least 8 bits and always wide enough to hold the limit.
    function automatic int timeout_cnt_width(input int unsigned cycles);
        int w;
        w = $clog2(cycles + 1);
        return (w > 8) ? w : 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/memory_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : memory_bus_arbiter
// Description : Round-robin arbiter granting a fetch port and a load/store
//               port single-outstanding access to one DRAM request channel,
//               with a transaction timeout and sticky error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_bus_arbiter
    import memory_bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    // fetch port (read only)
    input  logic                 f_req_valid,
    input  phys_memory_address_t f_req_addr,
    output logic                 f_req_ready,
    output logic                 f_resp_valid,
    output mem_word_t            f_resp_data,
    // load/store port
    input  logic                 s_req_valid,
    input  logic                 s_req_write,
    input  phys_memory_address_t s_req_addr,
    input  mem_word_t            s_req_wdata,
    output logic                 s_req_ready,
    output logic                 s_resp_valid,
    output mem_word_t            s_resp_data,
    // DRAM side
    output logic                 m_req_valid,
    output logic                 m_req_write,
    output phys_memory_address_t m_req_addr,
    output mem_word_t            m_req_wdata,
    input  logic                 m_req_ready,
    input  logic                 m_resp_valid,
    input  mem_word_t            m_resp_data,
    // status
    output logic                 timeout_err
);

    localparam int                c_cnt_w   = timeout_cnt_width(TIMEOUT_CYCLES);
    localparam logic [c_cnt_w-1:0] c_timeout = c_cnt_w'(TIMEOUT_CYCLES);

    arb_state_t           r_state;
    requester_t           r_last_grant;
    requester_t           r_owner;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_timeout_err;
    logic                 r_m_req_valid;
    logic                 r_m_req_write;
    phys_memory_address_t r_m_req_addr;
    mem_word_t            r_m_req_wdata;
    logic                 r_f_resp_valid;
    logic                 r_s_resp_valid;
    mem_word_t            r_f_resp_data;
    mem_word_t            r_s_resp_data;

    logic                 w_grant_any;
    requester_t           w_grant_id;
    logic [c_cnt_w-1:0]   w_cnt_inc;
    logic                 w_cnt_expired;

    // Grant decision: only in IDLE; on a tie the port not granted last wins.
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_id  = REQ_FETCH;
        if (r_state == ST_IDLE) begin
            if (f_req_valid && s_req_valid) begin
                w_grant_any = 1'b1;
                w_grant_id  = (r_last_grant == REQ_STORE) ? REQ_FETCH : REQ_STORE;
            end else if (f_req_valid) begin
                w_grant_any = 1'b1;
                w_grant_id  = REQ_FETCH;
            end else if (s_req_valid) begin
                w_grant_any = 1'b1;
                w_grant_id  = REQ_STORE;
            end
        end
    end

    // The count never exceeds the limit because expiry forces IDLE.
    assign w_cnt_inc     = r_cnt + c_cnt_w'(1);
    assign w_cnt_expired = (w_cnt_inc >= c_timeout);

    // Ready is a same-cycle acknowledge; rst_n gating keeps it low while reset
    // is asserted even though the held-in-reset state is IDLE.
    assign f_req_ready = rst_n & w_grant_any & (w_grant_id == REQ_FETCH);
    assign s_req_ready = rst_n & w_grant_any & (w_grant_id == REQ_STORE);

    assign m_req_valid  = r_m_req_valid;
    assign m_req_write  = r_m_req_write;
    assign m_req_addr   = r_m_req_addr;
    assign m_req_wdata  = r_m_req_wdata;
    assign f_resp_valid = r_f_resp_valid;
    assign f_resp_data  = r_f_resp_data;
    assign s_resp_valid = r_s_resp_valid;
    assign s_resp_data  = r_s_resp_data;
    assign timeout_err  = r_timeout_err;

    // Transaction FSM with registered DRAM request and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_last_grant   <= REQ_STORE;
            r_owner        <= REQ_FETCH;
            r_cnt          <= '0;
            r_timeout_err  <= 1'b0;
            r_m_req_valid  <= 1'b0;
            r_m_req_write  <= 1'b0;
            r_m_req_addr   <= '0;
            r_m_req_wdata  <= '0;
            r_f_resp_valid <= 1'b0;
            r_s_resp_valid <= 1'b0;
            r_f_resp_data  <= '0;
            r_s_resp_data  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_any) begin
                        r_owner       <= w_grant_id;
                        r_last_grant  <= w_grant_id;
                        r_cnt         <= '0;
                        r_m_req_valid <= 1'b1;
                        if (w_grant_id == REQ_FETCH) begin
                            r_m_req_write <= 1'b0;
                            r_m_req_addr  <= f_req_addr;
                            r_m_req_wdata <= '0;
                        end else begin
                            r_m_req_write <= s_req_write;
                            r_m_req_addr  <= s_req_addr;
                            r_m_req_wdata <= s_req_wdata;
                        end
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_cnt <= w_cnt_inc;
                    // The timeout budget is a hard deadline and wins over a
                    // handshake arriving in the same cycle.
                    if (w_cnt_expired) begin
                        r_timeout_err <= 1'b1;
                        r_m_req_valid <= 1'b0;
                        r_state       <= ST_IDLE;
                    end else if (m_req_ready) begin
                        r_m_req_valid <= 1'b0;
                        r_state       <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    r_cnt <= w_cnt_inc;
                    if (w_cnt_expired) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= ST_IDLE;
                    end else if (m_resp_valid) begin
                        if (r_owner == REQ_FETCH) begin
                            r_f_resp_valid <= 1'b1;
                            r_f_resp_data  <= m_resp_data;
                        end else begin
                            r_s_resp_valid <= 1'b1;
                            r_s_resp_data  <= r_m_req_write ? '0 : m_resp_data;
                        end
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_f_resp_valid <= 1'b0;
                    r_s_resp_valid <= 1'b0;
                    r_f_resp_data  <= '0;
                    r_s_resp_data  <= '0;
                    r_state        <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_memory_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_bus_arbiter
// Description : Directed self-checking bench for memory_bus_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_bus_arbiter;

    localparam int unsigned TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        f_req_valid;
    logic [20:0] f_req_addr;
    logic        f_req_ready;
    logic        f_resp_valid;
    logic [63:0] f_resp_data;
    logic        s_req_valid;
    logic        s_req_write;
    logic [20:0] s_req_addr;
    logic [63:0] s_req_wdata;
    logic        s_req_ready;
    logic        s_resp_valid;
    logic [63:0] s_resp_data;
    logic        m_req_valid;
    logic        m_req_write;
    logic [20:0] m_req_addr;
    logic [63:0] m_req_wdata;
    logic        m_req_ready;
    logic        m_resp_valid;
    logic [63:0] m_resp_data;
    logic        timeout_err;

    int n_cmp = 0;
    int n_err = 0;

    memory_bus_arbiter #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .f_req_valid  (f_req_valid),
        .f_req_addr   (f_req_addr),
        .f_req_ready  (f_req_ready),
        .f_resp_valid (f_resp_valid),
        .f_resp_data  (f_resp_data),
        .s_req_valid  (s_req_valid),
        .s_req_write  (s_req_write),
        .s_req_addr   (s_req_addr),
        .s_req_wdata  (s_req_wdata),
        .s_req_ready  (s_req_ready),
        .s_resp_valid (s_resp_valid),
        .s_resp_data  (s_resp_data),
        .m_req_valid  (m_req_valid),
        .m_req_write  (m_req_write),
        .m_req_addr   (m_req_addr),
        .m_req_wdata  (m_req_wdata),
        .m_req_ready  (m_req_ready),
        .m_resp_valid (m_resp_valid),
        .m_resp_data  (m_resp_data),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after driving inputs.
    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        f_req_valid  = 1'b0;
        f_req_addr   = '0;
        s_req_valid  = 1'b0;
        s_req_write  = 1'b0;
        s_req_addr   = '0;
        s_req_wdata  = '0;
        m_req_ready  = 1'b0;
        m_resp_valid = 1'b0;
        m_resp_data  = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n        = 1'b0;
        f_req_valid  = 1'b1;
        s_req_valid  = 1'b1;
        m_resp_valid = 1'b1;
        cyc();
        settle();
        n_cmp++;
        if ({f_req_ready, s_req_ready, f_resp_valid, s_resp_valid, m_req_valid, m_req_write, timeout_err} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b want 0000000",
                     {f_req_ready, s_req_ready, f_resp_valid, s_resp_valid, m_req_valid, m_req_write, timeout_err});
        end
        n_cmp++;
        if ({m_req_addr, m_req_wdata, f_resp_data, s_resp_data} !== '0) begin
            n_err++;
            $display("FAIL reset_data: got addr=%h wdata=%h fdata=%h sdata=%h want all 0",
                     m_req_addr, m_req_wdata, f_resp_data, s_resp_data);
        end
        do_reset();
    endtask

    task automatic test_fetch_read();
        do_reset();
        m_req_ready  = 1'b1;
        m_resp_valid = 1'b1;
        m_resp_data  = 64'hDEAD_BEEF;
        f_req_valid  = 1'b1;
        f_req_addr   = 21'h00100;
        settle();
        n_cmp++;
        if ({f_req_ready, s_req_ready} !== 2'b10) begin
            n_err++;
            $display("FAIL fetch_accept: got f/s ready %b want 10", {f_req_ready, s_req_ready});
        end
        cyc();
        f_req_valid = 1'b0;
        settle();
        n_cmp++;
        if ({m_req_valid, m_req_write, m_req_addr} !== {1'b1, 1'b0, 21'h00100}) begin
            n_err++;
            $display("FAIL fetch_issue: got valid=%b write=%b addr=%h want 1 0 00100",
                     m_req_valid, m_req_write, m_req_addr);
        end
        cyc();
        settle();
        n_cmp++;
        if ({m_req_valid, f_resp_valid} !== 2'b00) begin
            n_err++;
            $display("FAIL fetch_wait: got m_req_valid/f_resp_valid %b want 00", {m_req_valid, f_resp_valid});
        end
        cyc();
        settle();
        n_cmp++;
        if ({f_resp_valid, s_resp_valid, f_resp_data} !== {1'b1, 1'b0, 64'hDEAD_BEEF}) begin
            n_err++;
            $display("FAIL fetch_resp: got f=%b s=%b data=%h want 1 0 deadbeef",
                     f_resp_valid, s_resp_valid, f_resp_data);
        end
        cyc();
        settle();
        n_cmp++;
        if ({f_resp_valid, s_resp_valid} !== 2'b00) begin
            n_err++;
            $display("FAIL fetch_resp_pulse: got f/s resp_valid %b want 00", {f_resp_valid, s_resp_valid});
        end
    endtask

    task automatic test_round_robin();
        logic        exp_f;
        logic [63:0] got_data;
        do_reset();
        f_req_valid  = 1'b1;
        f_req_addr   = 21'h00111;
        s_req_valid  = 1'b1;
        s_req_write  = 1'b0;
        s_req_addr   = 21'h00222;
        m_req_ready  = 1'b1;
        m_resp_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_f       = ((k % 2) == 0);
            m_resp_data = 64'h1000 + 64'(k);
            settle();
            n_cmp++;
            if ({f_req_ready, s_req_ready} !== {exp_f, ~exp_f}) begin
                n_err++;
                $display("FAIL rr_grant[%0d]: got f/s ready %b want %b", k, {f_req_ready, s_req_ready}, {exp_f, ~exp_f});
            end
            cyc();
            settle();
            n_cmp++;
            if (m_req_addr !== (exp_f ? 21'h00111 : 21'h00222)) begin
                n_err++;
                $display("FAIL rr_addr[%0d]: got %h want %h", k, m_req_addr, exp_f ? 21'h00111 : 21'h00222);
            end
            cyc();
            cyc();
            settle();
            got_data = exp_f ? f_resp_data : s_resp_data;
            n_cmp++;
            if ({f_resp_valid, s_resp_valid} !== {exp_f, ~exp_f} || got_data !== 64'h1000 + 64'(k)) begin
                n_err++;
                $display("FAIL rr_resp[%0d]: got f/s valid %b data %h want %b data %h",
                         k, {f_resp_valid, s_resp_valid}, got_data, {exp_f, ~exp_f}, 64'h1000 + 64'(k));
            end
            n_cmp++;
            if ({f_req_ready, s_req_ready} !== 2'b00) begin
                n_err++;
                $display("FAIL rr_no_grant_in_resp[%0d]: got f/s ready %b want 00", k, {f_req_ready, s_req_ready});
            end
            cyc();
        end
        idle_inputs();
    endtask

    task automatic test_store_stall();
        idle_inputs();
        s_req_valid = 1'b1;
        s_req_write = 1'b1;
        s_req_addr  = 21'h00200;
        s_req_wdata = 64'h1234;
        settle();
        n_cmp++;
        if ({f_req_ready, s_req_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL store_accept: got f/s ready %b want 01", {f_req_ready, s_req_ready});
        end
        cyc();
        s_req_valid = 1'b0;
        s_req_addr  = 21'h1FFFF;
        s_req_wdata = 64'hFFFF;
        for (int i = 0; i < 5; i++) begin
            settle();
            n_cmp++;
            if ({m_req_valid, m_req_write, m_req_addr, m_req_wdata} !== {1'b1, 1'b1, 21'h00200, 64'h1234}) begin
                n_err++;
                $display("FAIL store_stable[%0d]: got valid=%b write=%b addr=%h wdata=%h want 1 1 00200 1234",
                         i, m_req_valid, m_req_write, m_req_addr, m_req_wdata);
            end
            cyc();
        end
        m_req_ready = 1'b1;
        cyc();
        m_req_ready  = 1'b0;
        m_resp_valid = 1'b1;
        m_resp_data  = 64'hFFFF_0000_CAFE;
        settle();
        n_cmp++;
        if (m_req_valid !== 1'b0) begin
            n_err++;
            $display("FAIL store_wait: got m_req_valid %b want 0", m_req_valid);
        end
        cyc();
        m_resp_valid = 1'b0;
        settle();
        n_cmp++;
        if ({s_resp_valid, f_resp_valid, s_resp_data, timeout_err} !== {1'b1, 1'b0, 64'h0, 1'b0}) begin
            n_err++;
            $display("FAIL store_ack: got s=%b f=%b data=%h terr=%b want 1 0 0 0",
                     s_resp_valid, f_resp_valid, s_resp_data, timeout_err);
        end
        cyc();
        settle();
        n_cmp++;
        if (s_resp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL store_ack_pulse: got %b want 0", s_resp_valid);
        end
    endtask

    task automatic test_timeout();
        idle_inputs();
        f_req_valid = 1'b1;
        f_req_addr  = 21'h00300;
        settle();
        n_cmp++;
        if (f_req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL to_accept: got %b want 1", f_req_ready);
        end
        cyc();
        f_req_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            settle();
            n_cmp++;
            if ({m_req_valid, timeout_err} !== 2'b10) begin
                n_err++;
                $display("FAIL to_pending[%0d]: got m_req_valid/timeout_err %b want 10", i, {m_req_valid, timeout_err});
            end
            cyc();
        end
        settle();
        n_cmp++;
        if ({timeout_err, m_req_valid, f_resp_valid} !== 3'b100) begin
            n_err++;
            $display("FAIL to_expired: got terr/m_req_valid/f_resp_valid %b want 100",
                     {timeout_err, m_req_valid, f_resp_valid});
        end
        f_req_valid  = 1'b1;
        f_req_addr   = 21'h00400;
        m_req_ready  = 1'b1;
        m_resp_valid = 1'b1;
        m_resp_data  = 64'h55AA;
        settle();
        n_cmp++;
        if (f_req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL to_idle_after: got f_req_ready %b want 1", f_req_ready);
        end
        cyc();
        f_req_valid = 1'b0;
        cyc();
        cyc();
        settle();
        n_cmp++;
        if ({f_resp_valid, f_resp_data, timeout_err} !== {1'b1, 64'h55AA, 1'b1}) begin
            n_err++;
            $display("FAIL to_next_fetch: got valid=%b data=%h terr=%b want 1 55aa 1",
                     f_resp_valid, f_resp_data, timeout_err);
        end
        cyc();
        settle();
        n_cmp++;
        if ({f_resp_valid, timeout_err} !== 2'b01) begin
            n_err++;
            $display("FAIL to_sticky: got f_resp_valid/terr %b want 01", {f_resp_valid, timeout_err});
        end
        idle_inputs();
    endtask

    task automatic test_reset_in_wait();
        idle_inputs();
        s_req_valid = 1'b1;
        s_req_write = 1'b1;
        s_req_addr  = 21'h003AB;
        s_req_wdata = 64'h77;
        m_req_ready = 1'b1;
        settle();
        n_cmp++;
        if (s_req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rw_accept: got %b want 1", s_req_ready);
        end
        cyc();
        s_req_valid = 1'b0;
        cyc();
        settle();
        n_cmp++;
        if ({m_req_valid, m_req_addr} !== {1'b0, 21'h003AB}) begin
            n_err++;
            $display("FAIL rw_in_wait: got valid=%b addr=%h want 0 003ab", m_req_valid, m_req_addr);
        end
        f_req_valid = 1'b1;
        rst_n       = 1'b0;
        #1;
        n_cmp++;
        if ({f_req_ready, s_req_ready, f_resp_valid, s_resp_valid, m_req_valid, m_req_write, timeout_err} !== 7'b0
            || {m_req_addr, m_req_wdata} !== '0) begin
            n_err++;
            $display("FAIL rw_async_reset: got flags=%b addr=%h wdata=%h want 0",
                     {f_req_ready, s_req_ready, f_resp_valid, s_resp_valid, m_req_valid, m_req_write, timeout_err},
                     m_req_addr, m_req_wdata);
        end
        cyc();
        idle_inputs();
        rst_n        = 1'b1;
        m_resp_valid = 1'b1;
        m_resp_data  = 64'hBAD;
        for (int i = 0; i < 4; i++) begin
            settle();
            n_cmp++;
            if ({f_resp_valid, s_resp_valid, m_req_valid} !== 3'b000) begin
                n_err++;
                $display("FAIL rw_late_resp[%0d]: got f/s/m valid %b want 000", i, {f_resp_valid, s_resp_valid, m_req_valid});
            end
            cyc();
        end
        idle_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by 100000 want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        test_reset();
        test_fetch_read();
        test_round_robin();
        test_store_stall();
        test_timeout();
        test_reset_in_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
